// File: rtl/sprite_renderer_pkg.sv
// Shared constants and types for the sprite renderer.
// LCD geometry, RGB565 colours, sprite IDs, FSM state.
package sprite_pkg;

    localparam int LCD_X_MAX = 239;
    localparam int LCD_Y_MAX = 319;

    localparam logic [15:0] COL_BG          = 16'hFFFF;
    localparam logic [15:0] COL_TRANSPARENT = 16'hF81F;

    localparam logic [3:0] ID_RUN0   = 4'd0;
    localparam logic [3:0] ID_RUN1   = 4'd1;
    localparam logic [3:0] ID_RUN2   = 4'd2;
    localparam logic [3:0] ID_JUMP   = 4'd3;
    localparam logic [3:0] ID_CROUCH = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ERASE = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/sprite_renderer_if.sv
// LCD pixel-write bus: coordinates, colour, write/ready handshake.
// master = renderer (drives pixel), slave = LCD (drives pixelReady).
interface sprite_renderer_if;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;

    modport master (
        output xAddr, yAddr, pixelData, pixelWrite,
        input  pixelReady
    );
    modport slave (
        input  xAddr, yAddr, pixelData, pixelWrite,
        output pixelReady
    );
endinterface

// File: rtl/sprite_renderer_scanner.sv
// Raster scanner over a W x H rectangle, column inner loop.
// Ports: start_i loads origin, advance_i steps; x/y/col/row, clipped, last out.
module rect_scanner #(
    parameter int W     = 32,
    parameter int H     = 32,
    parameter int X_MAX = 239,
    parameter int Y_MAX = 319
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 advance_i,
    input  logic [7:0]           ox_i,
    input  logic [8:0]           oy_i,
    output logic [7:0]           x_o,
    output logic [8:0]           y_o,
    output logic [$clog2(W)-1:0] col_o,
    output logic [$clog2(H)-1:0] row_o,
    output logic                 clipped_o,
    output logic                 last_o
);
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    ox_q, ox_d;
    logic [8:0]    oy_q, oy_d;
    logic [8:0]    xw;
    logic [9:0]    yw;
    logic          col_end;

    // One extra bit so coordinates past the panel edge never wrap
    assign xw = {1'b0, ox_q} + 9'(col_q);
    assign yw = {1'b0, oy_q} + 10'(row_q);

    assign col_end   = (col_q == CW'(W - 1));
    assign x_o       = xw[7:0];
    assign y_o       = yw[8:0];
    assign col_o     = col_q;
    assign row_o     = row_q;
    assign clipped_o = (xw > 9'(X_MAX)) || (yw > 10'(Y_MAX));
    assign last_o    = col_end && (row_q == RW'(H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        ox_d  = ox_q;
        oy_d  = oy_q;
        if (start_i) begin
            col_d = '0;
            row_d = '0;
            ox_d  = ox_i;
            oy_d  = oy_i;
        end else if (advance_i) begin
            col_d = col_end ? '0 : col_q + 1'b1;
            row_d = col_end ? row_q + 1'b1 : row_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
            ox_q  <= '0;
            oy_q  <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            ox_q  <= ox_d;
            oy_q  <= oy_d;
        end
    end
endmodule

// File: rtl/sprite_renderer.sv
// Sprite renderer: erases old sprite rectangle, draws new one from ROM.
// Ports: update/xSprite/ySprite/IdSprite in, ROM addr/data, LCD bus, busy, frameDone.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          ROM_AW      = 14,
    parameter logic [15:0] BG_COLOUR   = COL_BG,
    parameter logic [15:0] TRANSPARENT = COL_TRANSPARENT,
    parameter int          X_MAX       = LCD_X_MAX,
    parameter int          Y_MAX       = LCD_Y_MAX
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               update,
    input  logic [7:0]         xSprite,
    input  logic [8:0]         ySprite,
    input  logic [3:0]         IdSprite,
    output logic [ROM_AW-1:0]  romAddr,
    input  logic [15:0]        romData,
    sprite_renderer_if.master  lcd,
    output logic               busy,
    output logic               frameDone
);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);

    state_t state_q, state_d;

    logic [7:0]  nxt_x_q, cur_x_q, old_x_q, src_x, sc_ox;
    logic [8:0]  nxt_y_q, cur_y_q, old_y_q, src_y, sc_oy;
    logic [3:0]  nxt_id_q, cur_id_q, src_id;
    logic        old_vld_q, pend_q, done_q;
    logic [ROM_AW-1:0] rom_q;
    logic [7:0]  xa_q;
    logic [8:0]  ya_q;
    logic [15:0] pd_q, colour;
    logic        pw_q;

    logic          sc_start, sc_adv, sc_clip, sc_last;
    logic [7:0]    sc_x;
    logic [8:0]    sc_y;
    logic [CW-1:0] sc_col;
    logic [RW-1:0] sc_row;

    logic can_load, load, fetch, finish, take, step;

    // A fresh request in IDLE bypasses the latch so it starts at once
    assign src_x  = update ? xSprite  : nxt_x_q;
    assign src_y  = update ? ySprite  : nxt_y_q;
    assign src_id = update ? IdSprite : nxt_id_q;

    // Erase scans the old rectangle; draw always scans the current one
    assign sc_ox = (state_q != S_IDLE) ? cur_x_q :
                   old_vld_q ? old_x_q : src_x;
    assign sc_oy = (state_q != S_IDLE) ? cur_y_q :
                   old_vld_q ? old_y_q : src_y;

    // Output register is free when empty or being accepted now
    assign can_load = !pw_q || lcd.pixelReady;

    rect_scanner #(
        .W(SPRITE_W), .H(SPRITE_H), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
    ) u_scan (
        .clock(clock), .reset(reset),
        .start_i(sc_start), .advance_i(sc_adv),
        .ox_i(sc_ox), .oy_i(sc_oy),
        .x_o(sc_x), .y_o(sc_y), .col_o(sc_col), .row_o(sc_row),
        .clipped_o(sc_clip), .last_o(sc_last)
    );

    always_comb begin
        state_d  = state_q;
        sc_start = 1'b0;
        sc_adv   = 1'b0;
        load     = 1'b0;
        fetch    = 1'b0;
        finish   = 1'b0;
        take     = 1'b0;
        step     = 1'b0;
        colour   = BG_COLOUR;
        unique case (state_q)
            S_IDLE: begin
                if (update || pend_q) begin
                    take     = 1'b1;
                    sc_start = 1'b1;
                    state_d  = old_vld_q ? S_ERASE : S_FETCH;
                end
            end
            S_ERASE: begin
                // Clipped pixels burn one cycle and never touch the bus
                step = sc_clip || can_load;
                load = !sc_clip && can_load;
                if (step && sc_last) begin
                    sc_start = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    sc_adv = step;
                end
            end
            S_FETCH: begin
                if (!sc_clip) begin
                    fetch   = 1'b1;
                    state_d = S_WAIT;
                end else if (sc_last) begin
                    state_d = S_DONE;
                end else begin
                    sc_adv = 1'b1;
                end
            end
            S_WAIT: state_d = S_WRITE;
            S_WRITE: begin
                colour = (romData == TRANSPARENT) ? BG_COLOUR : romData;
                if (can_load) begin
                    load    = 1'b1;
                    sc_adv  = !sc_last;
                    state_d = sc_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                // Frame is complete only once the final write is taken
                if (can_load) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            nxt_x_q   <= '0;
            nxt_y_q   <= '0;
            nxt_id_q  <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            cur_id_q  <= '0;
            old_x_q   <= '0;
            old_y_q   <= '0;
            old_vld_q <= 1'b0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
            rom_q     <= '0;
            xa_q      <= '0;
            ya_q      <= '0;
            pd_q      <= '0;
            pw_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= finish;
            if (update) begin
                nxt_x_q  <= xSprite;
                nxt_y_q  <= ySprite;
                nxt_id_q <= IdSprite;
            end
            if (take) begin
                cur_x_q  <= src_x;
                cur_y_q  <= src_y;
                cur_id_q <= src_id;
                pend_q   <= 1'b0;
            end else if (update) begin
                pend_q <= 1'b1;
            end
            if (fetch) begin
                rom_q <= ROM_AW'({cur_id_q, sc_row, sc_col});
            end
            if (load) begin
                xa_q <= sc_x;
                ya_q <= sc_y;
                pd_q <= colour;
                pw_q <= 1'b1;
            end else if (lcd.pixelReady) begin
                pw_q <= 1'b0;
            end
            if (finish) begin
                old_x_q   <= cur_x_q;
                old_y_q   <= cur_y_q;
                old_vld_q <= 1'b1;
            end
        end
    end

    assign romAddr        = rom_q;
    assign lcd.xAddr      = xa_q;
    assign lcd.yAddr      = ya_q;
    assign lcd.pixelData  = pd_q;
    assign lcd.pixelWrite = pw_q;
    assign busy           = (state_q != S_IDLE);
    assign frameDone      = done_q;
endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: ROM model, LCD capture, frame checks.
// Expected pixel streams come from a rectangle/texel reference model.
module tb_sprite_renderer;
    typedef struct packed {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
    } px_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        update;
    logic [7:0]  xSprite;
    logic [8:0]  ySprite;
    logic [3:0]  IdSprite;
    logic [13:0] romAddr;
    logic [15:0] romData;
    logic        busy;
    logic        frameDone;

    sprite_renderer_if lcd ();

    sprite_renderer dut (
        .clock(clock), .reset(reset), .update(update),
        .xSprite(xSprite), .ySprite(ySprite), .IdSprite(IdSprite),
        .romAddr(romAddr), .romData(romData), .lcd(lcd),
        .busy(busy), .frameDone(frameDone)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] texel(input logic [13:0] a);
        if (a[4:0] == 5'd3) return 16'hF81F;
        return {2'b00, a} ^ 16'h1234;
    endfunction

    always @(posedge clock) romData <= texel(romAddr);

    // LCD side: ready always high, or high one cycle in three
    logic stall_en = 1'b0;
    int   ph = 0;
    always @(posedge clock) begin
        #1;
        ph = (ph == 2) ? 0 : ph + 1;
        lcd.pixelReady = !stall_en || (ph == 0);
    end

    px_t  cap[$];
    px_t  exp_q[$];
    int   fd_cnt = 0;
    int   stab_bad = 0;
    logic prev_stall = 1'b0;
    px_t  prev_px;

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!lcd.pixelWrite ||
                prev_px != px_t'{lcd.xAddr, lcd.yAddr, lcd.pixelData}))
                stab_bad++;
            prev_stall = lcd.pixelWrite && !lcd.pixelReady;
            prev_px = px_t'{lcd.xAddr, lcd.yAddr, lcd.pixelData};
            if (lcd.pixelWrite && lcd.pixelReady)
                cap.push_back(px_t'{lcd.xAddr, lcd.yAddr, lcd.pixelData});
            if (frameDone) fd_cnt++;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                      tag, got, got, want, want);
    endtask

    task automatic add_erase(input int ox, input int oy);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                if (ox + c <= 239 && oy + r <= 319)
                    exp_q.push_back(px_t'{8'(ox + c), 9'(oy + r), 16'hFFFF});
    endtask

    task automatic add_draw(input int ox, input int oy, input int id);
        logic [13:0] a;
        logic [15:0] t;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                if (ox + c <= 239 && oy + r <= 319) begin
                    a = {4'(id), 5'(r), 5'(c)};
                    t = texel(a);
                    if (t == 16'hF81F) t = 16'hFFFF;
                    exp_q.push_back(px_t'{8'(ox + c), 9'(oy + r), t});
                end
    endtask

    task automatic start_clear();
        cap.delete();
        exp_q.delete();
        fd_cnt = 0;
    endtask

    task automatic pulse(input int x, input int y, input int id);
        @(posedge clock);
        #1;
        update   = 1'b1;
        xSprite  = 8'(x);
        ySprite  = 9'(y);
        IdSprite = 4'(id);
        @(posedge clock);
        #1;
        update = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int n, output int cyc);
        cyc = 0;
        while (fd_cnt < n && cyc < 20000) begin
            @(posedge clock);
            cyc++;
        end
        check({tag, "_done"}, 32'(fd_cnt >= n), 1);
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic cmp_frame(input string tag, input int nfd);
        int bad = 0;
        int n;
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (cap[i] != exp_q[i]) bad++;
        check({tag, "_count"}, cap.size(), exp_q.size());
        check({tag, "_data"}, bad, 0);
        check({tag, "_fd"}, fd_cnt, nfd);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int cyc;
        int oob;
        reset    = 1'b1;
        update   = 1'b0;
        xSprite  = '0;
        ySprite  = '0;
        IdSprite = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_pw", 32'(lcd.pixelWrite), 0);
        check("rst_fd", 32'(frameDone), 0);
        check("rst_rom", 32'(romAddr), 0);
        check("rst_x", 32'(lcd.xAddr), 0);
        check("rst_data", 32'(lcd.pixelData), 0);
        reset = 1'b0;

        // 1: first frame, no erase
        start_clear();
        add_draw(95, 129, 0);
        pulse(95, 129, 0);
        wait_fd("t1", 1, cyc);
        cmp_frame("t1", 1);
        check("t1_rom_last", 32'(romAddr), 1023);

        // 2: erase then draw CROUCH
        start_clear();
        add_erase(95, 129);
        add_draw(73, 123, 4);
        pulse(73, 123, 4);
        wait_fd("t2", 1, cyc);
        cmp_frame("t2", 1);
        check("t2_rom_last", 32'(romAddr), 5119);

        // 3: LCD ready one cycle in three
        start_clear();
        stab_bad = 0;
        stall_en = 1'b1;
        add_erase(73, 123);
        add_draw(10, 20, 1);
        pulse(10, 20, 1);
        wait_fd("t3", 1, cyc);
        stall_en = 1'b0;
        cmp_frame("t3", 1);
        check("t3_stable", stab_bad, 0);
        check("t3_slow", 32'(cyc > 5000), 1);

        // 4: clipped at the panel corner
        start_clear();
        add_erase(10, 20);
        add_draw(230, 300, 2);
        pulse(230, 300, 2);
        wait_fd("t4", 1, cyc);
        cmp_frame("t4", 1);
        oob = 0;
        foreach (cap[i]) if (cap[i].x > 239 || cap[i].y > 319) oob++;
        check("t4_oob", oob, 0);
        check("t4_draw_px", cap.size() - 1024, 200);

        // 5: two updates while busy, newest wins
        start_clear();
        add_erase(230, 300);
        add_draw(50, 60, 3);
        add_erase(50, 60);
        add_draw(100, 200, 2);
        pulse(50, 60, 3);
        repeat (10) @(posedge clock);
        pulse(5, 6, 1);
        repeat (5) @(posedge clock);
        pulse(100, 200, 2);
        wait_fd("t5", 2, cyc);
        repeat (50) @(posedge clock);
        #1;
        cmp_frame("t5", 2);
        if (cap.size() > 2251)
            check("t5_transp", 32'(cap[2251].d), 32'hFFFF);
        else
            check("t5_transp_len", cap.size(), 2252);

        // 6: reset mid-draw, next frame has no erase
        start_clear();
        pulse(20, 30, 0);
        repeat (1500) @(posedge clock);
        #1;
        check("t6_busy_mid", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("t6_pw_rst", 32'(lcd.pixelWrite), 0);
        check("t6_busy_rst", 32'(busy), 0);
        reset = 1'b0;
        start_clear();
        add_draw(40, 50, 1);
        pulse(40, 50, 1);
        wait_fd("t6", 1, cyc);
        cmp_frame("t6", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
